// File: rtl/singleport_1rw_arb.sv
// ---------------------------------------------------------------------------
// singleport_1rw_arb
//
// Two-requester arbiter in front of a single-port 1RW synchronous RAM.
// Each cycle at most one of ports A/B is granted. A single priority bit
// decides ties and flips to the loser after every grant. Under continuous
// dual request the grants therefore alternate A,B,A,B.
// The granted access goes straight to the RAM in the same cycle. A granted
// read returns its data (ram_dout) one cycle later, flagged by that port's
// rvalid.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   a_req/a_we/a_addr/a_wdata  port A request (held until a_gnt)
//   a_gnt                      port A accepted this cycle (combinational)
//   a_rvalid/a_rdata           port A read data, one cycle after the grant
//   b_*                        identical set for port B
//   ram_en/ram_we              RAM enable / write enable (grant cycles only)
//   ram_addr/ram_di            RAM address / write data, held when idle
//   ram_dout                   RAM read data, 1-cycle latency
// ---------------------------------------------------------------------------
module singleport_1rw_arb #(
  parameter int AW = 10,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  // port A
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,
  // port B
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,
  // RAM side
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_di,
  input  logic [DW-1:0] ram_dout
);

  typedef enum logic {
    PRIO_A = 1'b0,
    PRIO_B = 1'b1
  } prio_e;

  prio_e         prio;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] di_q;

  // Grants are gated by rst_n so that nothing reaches the RAM while reset
  // is asserted, even with requests pending.
  assign a_gnt = rst_n & a_req & (~b_req | (prio == PRIO_A));
  assign b_gnt = rst_n & b_req & (~a_req | (prio == PRIO_B));

  assign ram_en = a_gnt | b_gnt;

  // The granted port drives the RAM directly. With no grant the last
  // granted address/data are replayed, so the RAM pins stay quiet when idle.
  // NOTE: every output of an always_comb gets a default before any branch;
  // a path that leaves one unassigned infers a latch.
  always_comb begin
    ram_we   = 1'b0;
    ram_addr = addr_q;
    ram_di   = di_q;
    if (a_gnt) begin
      ram_we   = a_we;
      ram_addr = a_addr;
      ram_di   = a_wdata;
    end else if (b_gnt) begin
      ram_we   = b_we;
      ram_addr = b_addr;
      ram_di   = b_wdata;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so that every
  // register samples values from before the edge, whatever the statement
  // order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio     <= PRIO_A;
      addr_q   <= '0;
      di_q     <= '0;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
    end else begin
      // The loser of this cycle gets priority next cycle. Idle cycles hold.
      if (a_gnt) begin
        prio <= PRIO_B;
      end else if (b_gnt) begin
        prio <= PRIO_A;
      end

      if (ram_en) begin
        addr_q <= ram_addr;
        di_q   <= ram_di;
      end

      // The RAM returns read data one cycle after the enable. Writes never
      // flag rvalid.
      a_rvalid <= a_gnt & ~a_we;
      b_rvalid <= b_gnt & ~b_we;
    end
  end

  // Both ports see the shared RAM output. Each port qualifies it with its
  // own rvalid.
  assign a_rdata = ram_dout;
  assign b_rdata = ram_dout;

endmodule

// File: tb/tb_singleport_1rw_arb.sv
// ---------------------------------------------------------------------------
// tb_singleport_1rw_arb
//
// Directed bench for singleport_1rw_arb with a behavioural 1RW RAM attached.
// For each cycle, a stimulus vector gives the expected grant. Each granted
// read pushes its expected response (port, data, cycle) into a scoreboard
// queue. A monitor on the falling edge pops that queue whenever an rvalid
// appears. Any read response that is missing, unexpected, or late is
// reported.
// ---------------------------------------------------------------------------
module tb_singleport_1rw_arb;

  localparam int AW = 10;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          a_req, a_we, b_req, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic          a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [DW-1:0] a_rdata, b_rdata;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_di;
  logic [DW-1:0] ram_dout;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int step_no  = 0;

  typedef struct {
    logic          port;  // 0 = A, 1 = B
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  exp_t          sb[$];
  logic [AW-1:0] exp_last_addr;
  logic [DW-1:0] exp_last_di;

  singleport_1rw_arb #(.AW(AW), .DW(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a_req    (a_req),
    .a_we     (a_we),
    .a_addr   (a_addr),
    .a_wdata  (a_wdata),
    .a_gnt    (a_gnt),
    .a_rvalid (a_rvalid),
    .a_rdata  (a_rdata),
    .b_req    (b_req),
    .b_we     (b_we),
    .b_addr   (b_addr),
    .b_wdata  (b_wdata),
    .b_gnt    (b_gnt),
    .b_rvalid (b_rvalid),
    .b_rdata  (b_rdata),
    .ram_en   (ram_en),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_di   (ram_di),
    .ram_dout (ram_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural single-port RAM. The read has 1-cycle latency, and dout
  // holds its value during writes and idle cycles.
  logic [DW-1:0] mem [1 << AW];
  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    mem[0] = 16'h1111;
    mem[1] = 16'h2222;
    mem[2] = 16'h3333;
    mem[3] = 16'h4444;
    ram_dout = '0;
  end
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_di;
      else        ram_dout      <= mem[ram_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares each read response against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (sb.size() > 0 && sb[0].cyc < cyc) begin
        check($sformatf("rvalid_missing_c%0d", sb[0].cyc), 32'd0, 32'd1);
        void'(sb.pop_front());
      end
      if (a_rvalid || b_rvalid) begin
        if (a_rvalid && b_rvalid)
          check("rvalid_both", 32'd1, 32'd0);
        if (sb.size() == 0) begin
          check("rvalid_unexpected", {30'd0, a_rvalid, b_rvalid}, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("rsp_port",  {31'd0, b_rvalid}, {31'd0, e.port});
          check("rsp_data",  {16'd0, (b_rvalid ? b_rdata : a_rdata)}, {16'd0, e.data});
          check("rsp_cycle", cyc, e.cyc);
        end
      end
    end
  end

  // Drive one cycle of requests and check the combinational grant and RAM
  // signals mid-cycle. For a granted read, queue the response expected
  // next cycle. The caller enters just after a rising edge; the task
  // returns just after the next one.
  task automatic step(
    input logic ar, input logic aw, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
    input logic br, input logic bw, input logic [AW-1:0] ba, input logic [DW-1:0] bd,
    input logic eg_a, input logic eg_b, input logic [DW-1:0] exp_rd
  );
    logic          x_we;
    logic [AW-1:0] x_addr;
    logic [DW-1:0] x_di;
    step_no++;
    a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
    b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
    x_we   = eg_a ? aw : (eg_b ? bw : 1'b0);
    x_addr = eg_a ? aa : (eg_b ? ba : exp_last_addr);
    x_di   = eg_a ? ad : (eg_b ? bd : exp_last_di);
    @(negedge clk);
    check($sformatf("s%0d_a_gnt", step_no),    {31'd0, a_gnt},  {31'd0, eg_a});
    check($sformatf("s%0d_b_gnt", step_no),    {31'd0, b_gnt},  {31'd0, eg_b});
    check($sformatf("s%0d_ram_en", step_no),   {31'd0, ram_en}, {31'd0, eg_a | eg_b});
    check($sformatf("s%0d_ram_we", step_no),   {31'd0, ram_we}, {31'd0, x_we});
    check($sformatf("s%0d_ram_addr", step_no), {22'd0, ram_addr}, {22'd0, x_addr});
    check($sformatf("s%0d_ram_di", step_no),   {16'd0, ram_di},   {16'd0, x_di});
    if ((eg_a || eg_b) && !x_we) begin
      exp_t e;
      e.port = eg_b;
      e.data = exp_rd;
      e.cyc  = cyc + 1;
      sb.push_back(e);
    end
    exp_last_addr = x_addr;
    exp_last_di   = x_di;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(0, 0, '0, '0, 0, 0, '0, '0, 0, 0, '0);
  endtask

  initial begin
    // Reset is asserted with both ports requesting. Nothing may leak through.
    rst_n = 1'b0;
    a_req = 1; a_we = 0; a_addr = 10'h000; a_wdata = '0;
    b_req = 1; b_we = 1; b_addr = 10'h001; b_wdata = 16'hAAAA;
    exp_last_addr = '0;
    exp_last_di   = '0;
    #3;
    check("rst_a_gnt",    {31'd0, a_gnt},    32'd0);
    check("rst_b_gnt",    {31'd0, b_gnt},    32'd0);
    check("rst_ram_en",   {31'd0, ram_en},   32'd0);
    check("rst_ram_we",   {31'd0, ram_we},   32'd0);
    check("rst_ram_addr", {22'd0, ram_addr}, 32'd0);
    check("rst_ram_di",   {16'd0, ram_di},   32'd0);
    check("rst_rvalid",   {30'd0, a_rvalid, b_rvalid}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Continuous dual reads: A,B,A,B, starting with A.
    step(1, 0, 10'h000, '0, 1, 0, 10'h001, '0, 1, 0, 16'h1111);
    step(1, 0, 10'h000, '0, 1, 0, 10'h001, '0, 0, 1, 16'h2222);
    step(1, 0, 10'h000, '0, 1, 0, 10'h001, '0, 1, 0, 16'h1111);
    step(1, 0, 10'h000, '0, 1, 0, 10'h001, '0, 0, 1, 16'h2222);

    // A writes 0xBEEF to 0x005; B reads it back in the very next cycle.
    step(1, 1, 10'h005, 16'hBEEF, 0, 0, '0, '0, 1, 0, '0);
    step(0, 0, '0, '0, 1, 0, 10'h005, '0, 0, 1, 16'hBEEF);

    // B alone, back-to-back reads of 0x000..0x003. prio stays with A.
    step(0, 0, '0, '0, 1, 0, 10'h000, '0, 0, 1, 16'h1111);
    step(0, 0, '0, '0, 1, 0, 10'h001, '0, 0, 1, 16'h2222);
    step(0, 0, '0, '0, 1, 0, 10'h002, '0, 0, 1, 16'h3333);
    step(0, 0, '0, '0, 1, 0, 10'h003, '0, 0, 1, 16'h4444);

    // B was granted while prio=A, so a tie now goes to A. B then follows.
    step(1, 0, 10'h002, '0, 1, 0, 10'h003, '0, 1, 0, 16'h3333);
    step(0, 0, '0, '0, 1, 0, 10'h003, '0, 0, 1, 16'h4444);

    // Top-of-range write with B idle, then idle cycles hold addr/data.
    step(1, 1, 10'h3FF, 16'h1234, 0, 0, '0, '0, 1, 0, '0);
    idle();
    idle();

    // prio=B after A's write. A withdraws after losing, which is legal.
    step(1, 0, 10'h000, '0, 1, 0, 10'h002, '0, 0, 1, 16'h3333);
    idle();

    // A read is granted, then reset is pulsed mid-way through the response
    // cycle.
    step(1, 0, 10'h001, '0, 0, 0, '0, '0, 1, 0, 16'h2222);
    check("pre_rst_a_rvalid", {31'd0, a_rvalid}, 32'd1);
    void'(sb.pop_front());  // response is consumed here, before the monitor edge
    a_req = 1; a_we = 0; a_addr = 10'h000;
    b_req = 1; b_we = 0; b_addr = 10'h001;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_a_rvalid", {31'd0, a_rvalid}, 32'd0);
    check("mid_rst_a_gnt",    {31'd0, a_gnt},    32'd0);
    check("mid_rst_ram_en",   {31'd0, ram_en},   32'd0);
    check("mid_rst_ram_addr", {22'd0, ram_addr}, 32'd0);
    exp_last_addr = '0;
    exp_last_di   = '0;
    @(posedge clk);
    #1;
    check("in_rst_rvalid", {30'd0, a_rvalid, b_rvalid}, 32'd0);
    #2;
    rst_n = 1'b1;
    // The first cycle after release arbitrates with prio=A.
    step(1, 0, 10'h000, '0, 1, 0, 10'h001, '0, 1, 0, 16'h1111);
    step(0, 0, '0, '0, 1, 0, 10'h001, '0, 0, 1, 16'h2222);
    idle();
    idle();
    idle();

    check("sb_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
